ram_march_bist: RTL and testbench
=================================

# ram_march_bist

Built-in self-test initiator for the team's 128x32 single-port RAM (synchronous write, combinational read). It drives the RAM's write-enable, address and write-data pins, checks read data on the same port, and runs a four-element March test with one cycle per address per element. It sits beside the RAM and is muxed onto the RAM port by the system during test mode. It reports pass/fail, the first failing address and phase, and an error count.

## Interface
- DATA_W, 32, RAM word width
- ADDR_W, 7, RAM address width (depth = 2**ADDR_W)
- PATTERN, 32'hA5A5_5A5A, background word P; ~P is its bitwise inverse
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  level-sampled run request
- busy  out  1  high while a March element is executing
- done  out  1  high in DONE until the next start
- fail  out  1  sticky, set on any read mismatch in the current run
- fail_addr  out  ADDR_W  address of first mismatch
- fail_phase  out  2  element of first mismatch: 1=R0W1, 2=R1W0, 3=R0
- err_count  out  8  mismatch count, saturates at 255
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_d  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data, combinational from ram_addr

## Operation
- States: IDLE, W0, R0W1, R1W0, R0, DONE.
- IDLE/DONE: start=1 at an edge -> W0, addr=0; clears fail, fail_addr, fail_phase, err_count, done. start ignored in all other states.
- W0: ascending 0..127, write P. At addr 127 -> R0W1, addr=0.
- R0W1: ascending; expect P on ram_q, write ~P same cycle. At 127 -> R1W0, addr=127.
- R1W0: descending 127..0; expect ~P, write P. At 0 -> R0, addr=0.
- R0: ascending; expect P, ram_we=0. At 127 -> DONE.
- Same-cycle read+write is legal: ram_q shows pre-edge contents, write commits at the edge.
- Mismatch (ram_q != expected, all DATA_W bits) in a read element: fail<=1; err_count<=err_count+1 unless 255; fail_addr/fail_phase loaded only if fail was 0.
- Test always completes all elements; no early abort on fail.
- Outside W0..R0: ram_we=0, ram_addr=0, ram_d=0.

## Timing
- Reset values: all outputs 0; state IDLE. Reset mid-run aborts immediately (ram_we drops asynchronously); no partial result retained.
- start sampled at edge T0 -> busy=1 and first write (addr 0) presented in cycle T1.
- Each element exactly 2**ADDR_W cycles; busy high T1..T512 (default size); done=1 and busy=0 from T513.
- ram_we, ram_addr, ram_d are registered state decodes, stable for the whole cycle; compare is combinational on ram_q, results registered at the cycle's closing edge, so fail/err_count reflect a mismatch one cycle after its address was presented.
- start held high continuously: back-to-back runs, one DONE cycle between runs.
- Element boundary: the terminal address is fully processed (read+write) before the transition; no idle cycles between elements.

## Structure
- Package ram_bist_pkg: state enum, phase code constants (PH_R0W1=1, PH_R1W0=2, PH_R0=3), default PATTERN.
- One sub-module: ram_bist_addr_gen, ADDR_W up/down loadable counter with terminal-count flag (up: all-ones, down: zero).
- Top holds the FSM, expected-data/write-data mux, comparator and result registers.

## Test plan
- Fault-free RAM model, start pulse at T0 -> busy T1..T512, done=1 at T513, fail=0, err_count=0, RAM holds P at all addresses.
- Bit 3 stuck-at-0 at address 0x15 (P bit 3 = 1) -> fail=1, fail_addr=0x15, fail_phase=1, err_count=2 (R0W1 and R0 miss, R1W0 passes).
- Bit 0 stuck-at-1 at every address (P bit 0 = 0) -> R0W1 and R0 each miss 128 words, err_count=255 saturated, fail_addr=0, fail_phase=1.
- start pulsed at cycle 100 of a run -> ignored, run still ends at T513; start held high through DONE -> second run begins one cycle after done, results cleared.
- rst_n asserted at cycle 200 mid R0W1 -> ram_we=0, busy=0, all outputs 0 immediately; new start gives clean pass with done at T513 relative to it.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// ----------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the RAM March BIST initiator.
//   bist_state_e    : March sequencer states (idle, four elements, done)
//   PH_*            : codes reported on fail_phase for the read elements
//   DEFAULT_PATTERN : background word P written in W0
// ----------------------------------------------------------------------------
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_W0   = 3'd1,
        ST_R0W1 = 3'd2,
        ST_R1W0 = 3'd3,
        ST_R0   = 3'd4,
        ST_DONE = 3'd5
    } bist_state_e;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_R0W1 = 2'd1;
    localparam logic [1:0] PH_R1W0 = 2'd2;
    localparam logic [1:0] PH_R0   = 2'd3;

    localparam logic [31:0] DEFAULT_PATTERN = 32'hA5A5_5A5A;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ----------------------------------------------------------------------------
// ram_bist_addr_gen
// Loadable up/down address counter for the March sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val on the next edge (has priority over en)
//   load_val   : value to load
//   en         : step the counter by one in the direction given by up
//   up         : 1 = count up, 0 = count down
//   addr       : current address
//   tc         : terminal count for the current direction
//                (all-ones when counting up, zero when counting down)
// ----------------------------------------------------------------------------
module ram_bist_addr_gen #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              en,
    input  logic              up,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (en) begin
            addr_d = up ? (addr_q + 1'b1) : (addr_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign tc   = up ? (addr_q == {ADDR_W{1'b1}}) : (addr_q == {ADDR_W{1'b0}});

endmodule

// File: rtl/ram_march_bist.sv
// ----------------------------------------------------------------------------
// ram_march_bist
// March BIST initiator for a single-port RAM with synchronous write and
// combinational read. Runs W0(up) / R0W1(up) / R1W0(down) / R0(up), one
// address per cycle, and reports the first failing address/phase plus a
// saturating mismatch count.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : run request, sampled in IDLE and DONE only
//   busy                : high while a March element is executing
//   done                : high in DONE until the next run starts
//   fail                : sticky mismatch flag for the current run
//   fail_addr/fail_phase: address and element of the first mismatch
//   err_count           : mismatch count, saturating at 255
//   ram_we/addr/d       : RAM write enable, address, write data
//   ram_q               : RAM read data (combinational from ram_addr)
// ----------------------------------------------------------------------------
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 7,
    parameter logic [DATA_W-1:0]  PATTERN = DEFAULT_PATTERN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [1:0]        fail_phase,
    output logic [7:0]        err_count,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [7:0] ERR_MAX = 8'hFF;

    bist_state_e state_q;
    bist_state_e state_d;

    logic [ADDR_W-1:0] addr;
    logic              tc;
    logic              cnt_load;
    logic [ADDR_W-1:0] cnt_load_val;
    logic              cnt_en;
    logic              cnt_up;

    logic              clear_run;
    logic              check_en;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        cur_phase;
    logic              mismatch;

    logic              fail_q,       fail_d;
    logic [ADDR_W-1:0] fail_addr_q,  fail_addr_d;
    logic [1:0]        fail_phase_q, fail_phase_d;
    logic [7:0]        err_count_q,  err_count_d;

    // Only R1W0 walks downwards; deriving direction straight from the state
    // keeps tc free of any path back through the output decode.
    assign cnt_up = (state_q != ST_R1W0);

    ram_bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .addr     (addr),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each element ends after its terminal address has been processed, so
    // the transition is taken on the cycle that presents that address.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_W0;
            ST_W0:            if (tc)    state_d = ST_R0W1;
            ST_R0W1:          if (tc)    state_d = ST_R1W0;
            ST_R1W0:          if (tc)    state_d = ST_R0;
            ST_R0:            if (tc)    state_d = ST_DONE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Moore decode of the RAM port plus counter control; the counter is
    // reloaded with the next element's first address on the terminal cycle.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_d        = '0;
        check_en     = 1'b0;
        exp_data     = '0;
        cur_phase    = PH_NONE;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        clear_run    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clear_run = start;
                cnt_load  = start;
            end
            ST_DONE: begin
                done      = 1'b1;
                clear_run = start;
                cnt_load  = start;
            end
            ST_W0: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = addr;
                ram_d    = PATTERN;
                cnt_load = tc;
                cnt_en   = ~tc;
            end
            ST_R0W1: begin
                busy         = 1'b1;
                ram_we       = 1'b1;
                ram_addr     = addr;
                ram_d        = ~PATTERN;
                check_en     = 1'b1;
                exp_data     = PATTERN;
                cur_phase    = PH_R0W1;
                cnt_load     = tc;
                cnt_load_val = {ADDR_W{1'b1}};
                cnt_en       = ~tc;
            end
            ST_R1W0: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = addr;
                ram_d     = PATTERN;
                check_en  = 1'b1;
                exp_data  = ~PATTERN;
                cur_phase = PH_R1W0;
                cnt_load  = tc;
                cnt_en    = ~tc;
            end
            ST_R0: begin
                busy      = 1'b1;
                ram_addr  = addr;
                check_en  = 1'b1;
                exp_data  = PATTERN;
                cur_phase = PH_R0;
                cnt_load  = tc;
                cnt_en    = ~tc;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ram_q shows pre-edge contents, so the compare is valid even while the
    // same cycle writes the complementary value.
    assign mismatch = check_en && (ram_q != exp_data);

    // First-failure capture only while fail is still clear; count saturates.
    always_comb begin
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_phase_d = fail_phase_q;
        err_count_d  = err_count_q;
        if (clear_run) begin
            fail_d       = 1'b0;
            fail_addr_d  = '0;
            fail_phase_d = PH_NONE;
            err_count_d  = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 8'd1;
            end
            if (!fail_q) begin
                fail_addr_d  = addr;
                fail_phase_d = cur_phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_phase_q <= PH_NONE;
            err_count_q  <= '0;
        end else begin
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_phase_q <= fail_phase_d;
            err_count_q  <= err_count_d;
        end
    end

    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_phase = fail_phase_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// ----------------------------------------------------------------------------
// tb_ram_march_bist
// Scoreboard bench for ram_march_bist with a behavioural 128x32 RAM that can
// inject stuck-at bits on the read path. Each started run pushes its expected
// result; a monitor pops and compares whenever done rises.
// ----------------------------------------------------------------------------
module tb_ram_march_bist;

    localparam logic [31:0] P = 32'hA5A5_5A5A;

    typedef struct {
        string      name;
        int         t1;
        logic       exp_fail;
        logic [6:0] exp_addr;
        logic [1:0] exp_phase;
        logic [7:0] exp_err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [6:0]  fail_addr;
    logic [1:0]  fail_phase;
    logic [7:0]  err_count;
    logic        ram_we;
    logic [6:0]  ram_addr;
    logic [31:0] ram_d;
    logic [31:0] ram_q;

    logic [31:0] mem [0:127];
    logic        fault_on;
    logic        fault_all;
    logic [6:0]  fault_addr;
    logic [31:0] sa0_mask;
    logic [31:0] sa1_mask;

    int   cyc;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    ram_march_bist dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
        .err_count  (err_count),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_q      (ram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: synchronous write, combinational read with stuck-at
    // masks applied on the read path.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end

    assign ram_q = (fault_on && (fault_all || ram_addr == fault_addr))
                   ? ((mem[ram_addr] & ~sa0_mask) | sa1_mask)
                   : mem[ram_addr];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Issues a one-cycle start pulse and queues the expected run result.
    task automatic applyStimulus(input string name, input logic e_fail,
                                 input logic [6:0] e_addr, input logic [1:0] e_phase,
                                 input logic [7:0] e_err, output int t1);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        t1 = cyc + 1;
        e.name = name; e.t1 = t1; e.exp_fail = e_fail;
        e.exp_addr = e_addr; e.exp_phase = e_phase; e.exp_err = e_err;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitDrain(input int limit);
        int guard = 0;
        while (sb_q.size() != 0 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare.
    initial begin
        logic prev_done;
        int   busy_run;
        exp_t e;
        prev_done = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                busy_run  = 0;
            end else begin
                if (busy) busy_run++;
                if (done && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("unexpected_done", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput({e.name, "_done_cycle"}, cyc, e.t1 + 512);
                        checkOutput({e.name, "_busy_cycles"}, busy_run, 512);
                        checkOutput({e.name, "_busy_low"}, busy, 0);
                        checkOutput({e.name, "_fail"}, fail, e.exp_fail);
                        checkOutput({e.name, "_fail_addr"}, fail_addr, e.exp_addr);
                        checkOutput({e.name, "_fail_phase"}, fail_phase, e.exp_phase);
                        checkOutput({e.name, "_err_count"}, err_count, e.exp_err);
                    end
                    busy_run = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   t1;
        int   bad;
        exp_t e;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        fault_on   = 1'b0;
        fault_all  = 1'b0;
        fault_addr = '0;
        sa0_mask   = '0;
        sa1_mask   = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy_done", {busy, done}, 2'b00);
        checkOutput("reset_fail", {fail, fail_addr, fail_phase}, '0);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_ram_port", {ram_we, ram_addr, ram_d}, '0);
        rst_n = 1'b1;

        // Fault-free run with a stray start pulse at cycle 100.
        applyStimulus("pass", 1'b0, 7'h00, 2'd0, 8'd0, t1);
        checkOutput("pass_busy_T2", busy, 1);
        waitUntil(t1 + 99);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain(1000);
        bad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== P) bad++;
        checkOutput("pass_ram_contents_bad_words", bad, 0);

        // Bit 3 stuck-at-0 at 0x15: R0W1 and R0 miss, R1W0 passes.
        fault_on = 1'b1; fault_all = 1'b0; fault_addr = 7'h15;
        sa0_mask = 32'h0000_0008; sa1_mask = 32'h0;
        applyStimulus("bit3_sa0", 1'b1, 7'h15, 2'd1, 8'd2, t1);
        waitUntil(t1 + 149);
        checkOutput("bit3_err_before", err_count, 0);
        @(negedge clk);
        checkOutput("bit3_err_after", {fail, err_count}, {1'b1, 8'd1});
        waitDrain(1000);

        // Bit 0 stuck-at-1 everywhere: 256 misses saturate at 255.
        fault_all = 1'b1; sa0_mask = 32'h0; sa1_mask = 32'h0000_0001;
        applyStimulus("bit0_sa1_all", 1'b1, 7'h00, 2'd1, 8'd255, t1);
        waitDrain(1000);

        // Back-to-back runs with start held: first faulty, second clean.
        fault_all = 1'b0; fault_addr = 7'h05;
        @(negedge clk);
        start = 1'b1;
        t1 = cyc + 1;
        e.name = "b2b_first"; e.t1 = t1; e.exp_fail = 1'b1;
        e.exp_addr = 7'h05; e.exp_phase = 2'd1; e.exp_err = 8'd2;
        sb_q.push_back(e);
        e.name = "b2b_second"; e.t1 = t1 + 513; e.exp_fail = 1'b0;
        e.exp_addr = 7'h00; e.exp_phase = 2'd0; e.exp_err = 8'd0;
        sb_q.push_back(e);
        waitUntil(t1 + 512);
        fault_on = 1'b0;
        checkOutput("b2b_first_done_fail", {done, fail}, 2'b11);
        @(negedge clk);
        checkOutput("b2b_second_cleared", {busy, done, fail, err_count}, {3'b100, 8'd0});
        waitUntil(t1 + 520);
        start = 1'b0;
        waitDrain(1200);

        // Reset asserted at cycle 200 while R0W1 is accumulating errors.
        fault_on = 1'b1; fault_all = 1'b1;
        @(negedge clk);
        start = 1'b1;
        t1 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        waitUntil(t1 + 199);
        checkOutput("abort_err_before_reset", {fail, err_count}, {1'b1, 8'd71});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ram_port", {ram_we, ram_addr, ram_d}, '0);
        checkOutput("abort_status", {busy, done, fail, fail_addr, fail_phase, err_count}, '0);
        @(negedge clk);
        rst_n    = 1'b1;
        fault_on = 1'b0;
        applyStimulus("post_reset", 1'b0, 7'h00, 2'd0, 8'd0, t1);
        waitDrain(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
